// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer_reader slice.
//   readState_t    : reader FSM states (IDLE/READ/DRAIN/FINISH)
//   DEFAULT_DATA_W : default word width
//   DEFAULT_ADDR_W : default memory address width
package buffer_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } readState_t;

endpackage

// File: rtl/buffer_fifo2.sv
// 2-entry synchronous FIFO with registered storage.
//   clk, rst  : rising-edge clock, synchronous active-high reset (empty, storage zeroed)
//   push      : write pushData this edge
//   pushData  : word to store
//   pop       : discard the head entry this edge
//   headData  : current head entry (stale when count == 0)
//   count     : number of stored entries, 0..2
// Simultaneous push and pop is legal and leaves count unchanged.
module buffer_fifo2 #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [DATA_W-1:0] headData,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] slot [2];
    logic              wrPtr;
    logic              rdPtr;

    assign headData = slot[rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                slot[i] <= '0;
            end
            wrPtr <= 1'b0;
            rdPtr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                slot[wrPtr] <= pushData;
                wrPtr       <= ~wrPtr;
            end
            if (pop) begin
                rdPtr <= ~rdPtr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // The producer's issue rule must keep these from ever firing.
    assert property (@(posedge clk) disable iff (rst) !(push && !pop && count == 2'd2))
        else $error("buffer_fifo2 overflow");
    assert property (@(posedge clk) disable iff (rst) !(pop && count == 2'd0))
        else $error("buffer_fifo2 underflow");

endmodule

// File: rtl/buffer_reader.sv
// Block reader: on start, reads `length` contiguous words beginning at
// `base_addr` from a synchronous single-port memory (1-cycle read latency)
// and streams them out in address order over valid/ready.
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   start               : command strobe, only honoured in IDLE
//   base_addr, length   : command parameters captured with start
//   busy, done          : command active / one-cycle completion pulse
//   mem_rd_en, mem_addr : memory read request
//   mem_rdata           : memory data, valid the cycle after mem_rd_en
//   out_valid, out_data, out_ready : output stream
module buffer_reader
    import buffer_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam logic [ADDR_W:0]   ONE_WORD  = 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = 1;

    readState_t      state;
    logic [ADDR_W:0] remaining;
    logic            inflight;
    logic            issue;
    logic            pop;
    logic [1:0]      fifoCount;
    logic [2:0]      occupancy;

    assign pop       = out_valid && out_ready;
    assign out_valid = (fifoCount != 2'd0);
    assign busy      = (state == READ) || (state == DRAIN);
    assign done      = (state == FINISH);
    assign mem_rd_en = issue;

    // Slots that will be held after this edge: stored words plus the word
    // returning from last cycle's read, minus the one leaving now. A new read
    // is only issued if its data is guaranteed a slot two edges from now.
    always_comb begin
        occupancy = {1'b0, fifoCount} + {2'b00, inflight} - {2'b00, pop};
        issue     = (state == READ) && (remaining != '0) && (occupancy < 3'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr  <= base_addr;
                        remaining <= length;
                        state     <= (length == '0) ? FINISH : READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        mem_addr  <= mem_addr + ADDR_STEP;
                        remaining <= remaining - ONE_WORD;
                        if (remaining == ONE_WORD) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Last word leaves when nothing else is stored or returning.
                    if (pop && fifoCount == 2'd1 && !inflight) begin
                        state <= FINISH;
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // inflight clears on reset, so data from a read issued before reset is
    // never pushed.
    buffer_fifo2 #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .pushData (mem_rdata),
        .pop      (pop),
        .headData (out_data),
        .count    (fifoCount)
    );

endmodule
